// File: rtl/cpc_ram_pkg.sv
// -----------------------------------------------------------------------------
// cpc_ram_pkg
// Shared types and widths for the CPC expansion-SRAM auxiliary arbiter.
//   arb_state_t : arbiter sequencing states
//   SRAM_ADR_W  : full SRAM byte-address width (512K)
//   ADRLO_W     : low address bits driven through the external buffers
//   ADRHI_W     : high address bits driven directly (A18..A14)
// -----------------------------------------------------------------------------
package cpc_ram_pkg;

    localparam int SRAM_ADR_W = 19;
    localparam int ADRLO_W    = 14;
    localparam int ADRHI_W    = SRAM_ADR_W - ADRLO_W;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,   // no request pending
        WAIT_WIN = 2'd1,   // waiting for a refresh window
        ACCESS   = 2'd2,   // auxiliary access on the SRAM pins
        DONE     = 2'd3    // completion cycle
    } arb_state_t;

endpackage

// File: rtl/arb_timeout_ctr.sv
// -----------------------------------------------------------------------------
// arb_timeout_ctr
// 8-bit saturating cycle counter used as the auxiliary starvation timer.
// Ports:
//   clk, reset_b : clock, asynchronous active-low reset
//   clr          : synchronous clear to 0 (wins over en)
//   en           : count up by one this cycle, holding at 8'hFF
//   tc           : terminal count, high while the count equals TIMEOUT
// -----------------------------------------------------------------------------
module arb_timeout_ctr #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_b,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT);

    logic [7:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            count <= 8'h00;
        end else if (clr) begin
            count <= 8'h00;
        end else if (en && (count != 8'hFF)) begin
            count <= count + 8'h01;
        end
    end

    assign tc = (count == TC_VAL);

endmodule

// File: rtl/cpc_sram_aux_arbiter.sv
// -----------------------------------------------------------------------------
// cpc_sram_aux_arbiter
// Shares the CPC 512K expansion SRAM between the Z80 (always priority) and one
// auxiliary requester. Auxiliary accesses are placed inside Z80 refresh windows,
// during which bank decode guarantees the CPU is not addressing expansion RAM.
// An access cut short by the end of refresh retries at the next window; a
// request that sees no window for TIMEOUT cycles is failed with aux_err.
//
// Build option: define AUX_WRITE_EN to enable auxiliary writes. Without it,
// aux_we is ignored (all accesses are reads), sram_data_o is 0 and sram_we_b
// always follows cpu_we_b.
//
// Ports:
//   clk, reset_b               : 4 MHz CPC clock, async active-low reset
//   rfsh_b, mreq_b             : Z80 refresh / memory-request strobes
//   cpu_ramcs_b, cpu_adrhi,
//   cpu_oe_b, cpu_we_b         : CPU-side SRAM controls from bank decode
//   aux_req/we/adr/wdata       : auxiliary request (level held until aux_ack)
//   aux_ack, aux_err, aux_rdata: completion pulse, timeout flag, read data
//   sram_cs_b/oe_b/we_b,
//   sram_adrhi, sram_adrlo     : SRAM pins (adrlo valid when aux_bus_en)
//   aux_bus_en                 : enables external low-address/data buffers
//   sram_data_i, sram_data_o   : SRAM data bus read / write sides
// -----------------------------------------------------------------------------
module cpc_sram_aux_arbiter
    import cpc_ram_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  rfsh_b,
    input  logic                  mreq_b,
    input  logic                  cpu_ramcs_b,
    input  logic [ADRHI_W-1:0]    cpu_adrhi,
    input  logic                  cpu_oe_b,
    input  logic                  cpu_we_b,
    input  logic                  aux_req,
    input  logic                  aux_we,
    input  logic [SRAM_ADR_W-1:0] aux_adr,
    input  logic [7:0]            aux_wdata,
    output logic                  aux_ack,
    output logic                  aux_err,
    output logic [7:0]            aux_rdata,
    output logic                  sram_cs_b,
    output logic                  sram_oe_b,
    output logic                  sram_we_b,
    output logic [ADRHI_W-1:0]    sram_adrhi,
    output logic [ADRLO_W-1:0]    sram_adrlo,
    output logic                  aux_bus_en,
    input  logic [7:0]            sram_data_i,
    output logic [7:0]            sram_data_o
);

    arb_state_t state, state_nxt;
    logic       rfsh_q;
    logic       ack_nxt, err_nxt, load_rdata;
    logic       ctr_clr, ctr_en, ctr_tc;
    logic       is_write;
    logic       window;
    logic       guard;

`ifdef AUX_WRITE_EN
    assign is_write    = aux_we;
    assign sram_data_o = aux_wdata;
`else
    logic unused_wr;
    assign is_write    = 1'b0;
    assign sram_data_o = 8'h00;
    assign unused_wr   = ^{aux_we, aux_wdata};
`endif

    // First T-state of a refresh cycle: refresh just went active this edge.
    assign window = !rfsh_b && !mreq_b && rfsh_q;
    // Combinational so an early end of refresh releases aux drive at once.
    assign guard  = !rfsh_b;

    assign ctr_en = (state == WAIT_WIN);

    arb_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
        .clk     (clk),
        .reset_b (reset_b),
        .clr     (ctr_clr),
        .en      (ctr_en),
        .tc      (ctr_tc)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state     <= IDLE;
            rfsh_q    <= 1'b1;
            aux_ack   <= 1'b0;
            aux_err   <= 1'b0;
            aux_rdata <= 8'h00;
        end else begin
            state   <= state_nxt;
            rfsh_q  <= rfsh_b;
            aux_ack <= ack_nxt;
            aux_err <= err_nxt;
            if (load_rdata) begin
                aux_rdata <= sram_data_i;
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt  = state;
        ack_nxt    = 1'b0;
        err_nxt    = 1'b0;
        load_rdata = 1'b0;
        ctr_clr    = 1'b0;
        case (state)
            IDLE: begin
                if (aux_req) begin
                    state_nxt = WAIT_WIN;
                    ctr_clr   = 1'b1;
                end
            end
            WAIT_WIN: begin
                if (!aux_req) begin
                    state_nxt = IDLE;
                end else if (window) begin
                    state_nxt = ACCESS;
                end else if (ctr_tc) begin
                    state_nxt = IDLE;
                    ack_nxt   = 1'b1;
                    err_nxt   = 1'b1;
                end
            end
            ACCESS: begin
                // Completion ignores aux_req: a started access always finishes.
                if (!rfsh_b) begin
                    state_nxt  = DONE;
                    ack_nxt    = 1'b1;
                    load_rdata = !is_write;
                end else begin
                    // Refresh ended early: retry, keeping the timeout count.
                    state_nxt = WAIT_WIN;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // SRAM pin mux: CPU pass-through except while an aux access owns the pins.
    always_comb begin
        sram_cs_b  = cpu_ramcs_b;
        sram_oe_b  = cpu_oe_b;
        sram_we_b  = cpu_we_b;
        sram_adrhi = cpu_adrhi;
        sram_adrlo = '0;
        aux_bus_en = 1'b0;
        if (state == ACCESS) begin
            sram_cs_b  = !guard;
            aux_bus_en = guard;
            sram_adrhi = aux_adr[SRAM_ADR_W-1:ADRLO_W];
            sram_adrlo = aux_adr[ADRLO_W-1:0];
            sram_oe_b  = is_write ? 1'b1 : !guard;
`ifdef AUX_WRITE_EN
            // Write strobe only in the clk-low half so address/data settle first.
            sram_we_b  = is_write ? !(guard && !clk) : 1'b1;
`endif
        end
    end

endmodule

// File: tb/tb_cpc_sram_aux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cpc_sram_aux_arbiter
// Directed bench for cpc_sram_aux_arbiter (TIMEOUT = 10) with a byte-wide SRAM
// model. Covers reset/pass-through, aux reads, aux writes (AUX_WRITE_EN) or
// write-ignored reads (default build), early refresh abort and retry, request
// withdrawal, starvation timeout, CPU priority and reset during ACCESS.
// -----------------------------------------------------------------------------
module tb_cpc_sram_aux_arbiter;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        rfsh_b, mreq_b;
    logic        cpu_ramcs_b, cpu_oe_b, cpu_we_b;
    logic [4:0]  cpu_adrhi;
    logic        aux_req, aux_we;
    logic [18:0] aux_adr;
    logic [7:0]  aux_wdata;
    logic        aux_ack, aux_err;
    logic [7:0]  aux_rdata;
    logic        sram_cs_b, sram_oe_b, sram_we_b;
    logic [4:0]  sram_adrhi;
    logic [13:0] sram_adrlo;
    logic        aux_bus_en;
    logic [7:0]  sram_data_i, sram_data_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [0:(1<<19)-1];

    always #5 clk = ~clk;

    cpc_sram_aux_arbiter #(.TIMEOUT(10)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .rfsh_b      (rfsh_b),
        .mreq_b      (mreq_b),
        .cpu_ramcs_b (cpu_ramcs_b),
        .cpu_adrhi   (cpu_adrhi),
        .cpu_oe_b    (cpu_oe_b),
        .cpu_we_b    (cpu_we_b),
        .aux_req     (aux_req),
        .aux_we      (aux_we),
        .aux_adr     (aux_adr),
        .aux_wdata   (aux_wdata),
        .aux_ack     (aux_ack),
        .aux_err     (aux_err),
        .aux_rdata   (aux_rdata),
        .sram_cs_b   (sram_cs_b),
        .sram_oe_b   (sram_oe_b),
        .sram_we_b   (sram_we_b),
        .sram_adrhi  (sram_adrhi),
        .sram_adrlo  (sram_adrlo),
        .aux_bus_en  (aux_bus_en),
        .sram_data_i (sram_data_i),
        .sram_data_o (sram_data_o)
    );

    // SRAM model: reads only when the aux side owns the bus.
    assign sram_data_i = (!sram_cs_b && !sram_oe_b && aux_bus_en) ?
                         mem[{sram_adrhi, sram_adrlo}] : 8'h00;

    always @(negedge clk) begin
        #1;
        if (!sram_cs_b && !sram_we_b && aux_bus_en) begin
            mem[{sram_adrhi, sram_adrlo}] = sram_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to 2 time units after the next rising edge (clk-high phase).
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // One aux transaction through a single 2-cycle refresh.
    task automatic do_aux(input logic we, input logic [18:0] adr, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input string tag);
        aux_req   = 1'b1;
        aux_we    = we;
        aux_adr   = adr;
        aux_wdata = wd;
        step();                                   // IDLE -> WAIT_WIN
        check({tag, "_wait_busen"}, aux_bus_en, 0);
        rfsh_b = 1'b0;
        mreq_b = 1'b0;
        #1;
        check({tag, "_wait_cs"}, sram_cs_b, 1);
        step();                                   // WAIT_WIN -> ACCESS
        check({tag, "_acc_busen"}, aux_bus_en, 1);
        check({tag, "_acc_cs"}, sram_cs_b, 0);
        check({tag, "_acc_adrhi"}, sram_adrhi, adr[18:14]);
        check({tag, "_acc_adrlo"}, sram_adrlo, adr[13:0]);
        check({tag, "_acc_ack"}, aux_ack, 0);
`ifdef AUX_WRITE_EN
        if (we) begin
            check({tag, "_acc_oe"}, sram_oe_b, 1);
            check({tag, "_acc_we_hi_phase"}, sram_we_b, 1);
            check({tag, "_acc_wdata"}, sram_data_o, wd);
            @(negedge clk);
            #1;
            check({tag, "_acc_we_lo_phase"}, sram_we_b, 0);
        end else begin
            check({tag, "_acc_oe"}, sram_oe_b, 0);
            check({tag, "_acc_we"}, sram_we_b, 1);
        end
`else
        check({tag, "_acc_oe"}, sram_oe_b, 0);
        check({tag, "_acc_we"}, sram_we_b, 1);
        check({tag, "_acc_dout"}, sram_data_o, 8'h00);
        @(negedge clk);
        #1;
        check({tag, "_acc_we_lo_phase"}, sram_we_b, 1);
`endif
        step();                                   // ACCESS -> DONE
        check({tag, "_done_ack"}, aux_ack, 1);
        check({tag, "_done_err"}, aux_err, 0);
`ifdef AUX_WRITE_EN
        if (!we) check({tag, "_rdata"}, aux_rdata, exp_rd);
`else
        check({tag, "_rdata"}, aux_rdata, exp_rd);
`endif
        aux_req = 1'b0;
        rfsh_b  = 1'b1;
        mreq_b  = 1'b1;
        #1;
        check({tag, "_done_busen"}, aux_bus_en, 0);
        step();                                   // DONE -> IDLE
        check({tag, "_idle_ack"}, aux_ack, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem[19'h12345] = 8'hA5;
        mem[19'h00001] = 8'h5A;
        mem[19'h7FFFF] = 8'h77;

        // Reset with non-idle CPU values to see the pass-through.
        reset_b     = 1'b0;
        rfsh_b      = 1'b1;
        mreq_b      = 1'b1;
        cpu_ramcs_b = 1'b0;
        cpu_adrhi   = 5'h15;
        cpu_oe_b    = 1'b0;
        cpu_we_b    = 1'b1;
        aux_req     = 1'b0;
        aux_we      = 1'b0;
        aux_adr     = '0;
        aux_wdata   = 8'h00;
        step();
        check("rst_ack", aux_ack, 0);
        check("rst_err", aux_err, 0);
        check("rst_rdata", aux_rdata, 8'h00);
        check("rst_busen", aux_bus_en, 0);
        check("rst_cs", sram_cs_b, 0);
        check("rst_oe", sram_oe_b, 0);
        check("rst_adrhi", sram_adrhi, 5'h15);
        cpu_ramcs_b = 1'b1;
        cpu_oe_b    = 1'b1;
        cpu_adrhi   = 5'h03;
        reset_b     = 1'b1;
        step();

        // Read: A5 from 0x12345 (A18..A14 = 4, A13..A0 = 0x2345).
        do_aux(1'b0, 19'h12345, 8'h00, 8'hA5, "rd");

`ifdef AUX_WRITE_EN
        do_aux(1'b1, 19'h7FFFF, 8'h3C, 8'h00, "wr");
        do_aux(1'b0, 19'h7FFFF, 8'h00, 8'h3C, "rdback");
`else
        // aux_we ignored: behaves as a read of the preloaded 0x77.
        do_aux(1'b1, 19'h7FFFF, 8'h3C, 8'h77, "wr_ignored");
`endif

        // Early abort: refresh ends mid-ACCESS, retry on next window.
        aux_req = 1'b1;
        aux_we  = 1'b0;
        aux_adr = 19'h00001;
        step();
        rfsh_b = 1'b0;
        mreq_b = 1'b0;
        step();
        check("abort_cs_on", sram_cs_b, 0);
        rfsh_b = 1'b1;
        #1;
        check("abort_cs_rel", sram_cs_b, 1);
        check("abort_oe_rel", sram_oe_b, 1);
        check("abort_busen_rel", aux_bus_en, 0);
        mreq_b = 1'b1;
        step();
        check("abort_ack0", aux_ack, 0);
        step();
        check("abort_ack1", aux_ack, 0);
        rfsh_b = 1'b0;
        mreq_b = 1'b0;
        step();
        check("retry_busen", aux_bus_en, 1);
        step();
        check("retry_ack", aux_ack, 1);
        check("retry_err", aux_err, 0);
        check("retry_rdata", aux_rdata, 8'h5A);
        rfsh_b  = 1'b1;
        mreq_b  = 1'b1;
        aux_req = 1'b0;
        step();
        check("retry_ack_end", aux_ack, 0);

        // Request withdrawn in WAIT_WIN: back to IDLE, no ack, refresh ignored.
        aux_req = 1'b1;
        step();
        aux_req = 1'b0;
        step();
        check("drop_ack", aux_ack, 0);
        rfsh_b = 1'b0;
        mreq_b = 1'b0;
        step();
        check("drop_busen", aux_bus_en, 0);
        check("drop_ack2", aux_ack, 0);
        rfsh_b = 1'b1;
        mreq_b = 1'b1;
        step();

        // Timeout: TIMEOUT=10, no refresh; ack+err after the 11th edge.
        aux_req = 1'b1;
        step();
        for (int i = 1; i <= 10; i++) begin
            step();
            check($sformatf("to_ack_c%0d", i), aux_ack, 0);
            check($sformatf("to_cs_c%0d", i), sram_cs_b, 1);
            check($sformatf("to_busen_c%0d", i), aux_bus_en, 0);
        end
        step();
        check("to_ack", aux_ack, 1);
        check("to_err", aux_err, 1);
        aux_req = 1'b0;
        step();
        check("to_ack_end", aux_ack, 0);
        check("to_err_end", aux_err, 0);

        // CPU priority while aux pending, then reset during ACCESS.
        aux_req = 1'b1;
        aux_adr = 19'h28000;
        step();
        cpu_ramcs_b = 1'b0;
        cpu_we_b    = 1'b0;
        cpu_oe_b    = 1'b1;
        cpu_adrhi   = 5'h0A;
        mreq_b      = 1'b0;
        #1;
        check("cpu_cs", sram_cs_b, 0);
        check("cpu_we", sram_we_b, 0);
        check("cpu_oe", sram_oe_b, 1);
        check("cpu_adrhi", sram_adrhi, 5'h0A);
        check("cpu_busen", aux_bus_en, 0);
        step();
        cpu_we_b  = 1'b1;
        cpu_oe_b  = 1'b0;
        cpu_adrhi = 5'h1B;
        #1;
        check("cpu_we2", sram_we_b, 1);
        check("cpu_oe2", sram_oe_b, 0);
        check("cpu_adrhi2", sram_adrhi, 5'h1B);
        check("cpu_busen2", aux_bus_en, 0);
        cpu_ramcs_b = 1'b1;
        cpu_oe_b    = 1'b1;
        cpu_adrhi   = 5'h03;
        mreq_b      = 1'b1;
        step();
        rfsh_b = 1'b0;
        mreq_b = 1'b0;
        step();
        check("pre_rst_busen", aux_bus_en, 1);
        check("pre_rst_adrhi", sram_adrhi, 5'h0A);
        reset_b = 1'b0;
        #1;
        check("rst_acc_busen", aux_bus_en, 0);
        check("rst_acc_cs", sram_cs_b, 1);
        check("rst_acc_oe", sram_oe_b, 1);
        check("rst_acc_adrhi", sram_adrhi, 5'h03);
        step();
        check("rst_acc_ack", aux_ack, 0);
        check("rst_acc_rdata", aux_rdata, 8'h00);
        rfsh_b  = 1'b1;
        mreq_b  = 1'b1;
        aux_req = 1'b0;
        reset_b = 1'b1;
        step();
        check("post_rst_ack", aux_ack, 0);
        step();
        check("post_rst_ack2", aux_ack, 0);
        check("post_rst_busen", aux_bus_en, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
